db_agen_buffer: RTL and testbench

Parametrised double buffer with an N-dimensional strided read address generator. It is the next-generation successor of the fixed 16-bit, 3-D double-buffer memory-core mode and sits between a streaming producer and a compute tile. One bank is filled sequentially while the other bank is drained in stride/range order. Banks swap automatically once both sides finish, so no external `switch_db` is needed.

---
 rtl/db_agen_pkg.sv | 29 ++
 rtl/db_agen.sv | 89 ++++++++
 rtl/db_agen_buffer.sv | 168 ++++++++++++++++
 tb/tb_db_agen_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/db_agen_pkg.sv
// Shared types and limits for the double buffer with strided read address generator.
package db_agen_pkg;

  localparam int unsigned MAX_DIMS  = 6;
  localparam int unsigned CFG_CNT_W = 16;
  localparam int unsigned CFG_AW    = 6;
  localparam int unsigned CFG_DIMS  = 3;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DONE = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_DRAIN = 2'd1,
    R_DONE  = 2'd2
  } rd_state_t;

  // Configuration image at the default geometry
  typedef struct packed {
    logic [CFG_CNT_W-1:0]                depth;
    logic [CFG_AW-1:0]                   start;
    logic [CFG_DIMS-1:0][CFG_CNT_W-1:0]  stride;
    logic [CFG_DIMS-1:0][CFG_CNT_W-1:0]  range;
  } cfg_t;

endpackage

// File: rtl/db_agen.sv
// Nested DIMS-loop index counter producing a strided, wrapping read address.
module db_agen
  import db_agen_pkg::*;
#(
  parameter int unsigned DIMS  = 3,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned AW    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       step,
  input  logic [AW-1:0]              base,
  input  logic [DIMS-1:0][CNT_W-1:0] stride,
  input  logic [DIMS-1:0][CNT_W-1:0] range,
  output logic [AW-1:0]              addr,
  output logic                       last
);

  localparam int unsigned SUM_W = CNT_W + AW;

  if (DIMS < 1 || DIMS > MAX_DIMS) begin : g_dims_chk
    $error("db_agen: DIMS out of range");
  end

  logic [DIMS-1:0][CNT_W-1:0] idx_q;
  logic [DIMS-1:0][CNT_W-1:0] idx_d;
  logic [DIMS-1:0][SUM_W-1:0] off_q;
  logic [DIMS-1:0][SUM_W-1:0] off_d;
  logic [DIMS-1:0]            wrap;
  logic                       carry;
  logic [SUM_W-1:0]           sum;

  // Terminal count per dimension
  always_comb begin
    wrap = '0;
    for (int d = 0; d < DIMS; d++) begin
      wrap[d] = (idx_q[d] == range[d] - CNT_W'(1));
    end
  end

  assign last = &wrap;

  // Carry ripples outward from dim 0; running offsets replace multiplies
  always_comb begin
    idx_d = idx_q;
    off_d = off_q;
    carry = step;
    if (start) begin
      idx_d = '0;
      off_d = '0;
    end else begin
      for (int d = 0; d < DIMS; d++) begin
        if (carry) begin
          if (wrap[d]) begin
            idx_d[d] = '0;
            off_d[d] = '0;
          end else begin
            idx_d[d] = idx_q[d] + CNT_W'(1);
            off_d[d] = off_q[d] + SUM_W'(stride[d]);
          end
        end
        carry = carry & wrap[d];
      end
    end
  end

  // Base plus per-dimension offsets, wrapped to the bank size
  always_comb begin
    sum = SUM_W'(base);
    for (int d = 0; d < DIMS; d++) begin
      sum = sum + off_q[d];
    end
  end

  assign addr = sum[AW-1:0];

  // Index and offset registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      off_q <= '0;
    end else begin
      idx_q <= idx_d;
      off_q <= off_d;
    end
  end

endmodule

// File: rtl/db_agen_buffer.sv
// Double buffer: sequential fill of one bank while the other drains in strided order.
module db_agen_buffer
  import db_agen_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned DIMS   = 3,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_load,
  input  logic [CNT_W-1:0]           cfg_depth,
  input  logic [AW-1:0]              cfg_start,
  input  logic [DIMS-1:0][CNT_W-1:0] cfg_stride,
  input  logic [DIMS-1:0][CNT_W-1:0] cfg_range,
  output logic                       cfg_busy,
  output logic                       cfg_err,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       wr_bank,
  output logic [CNT_W-1:0]           swap_cnt
);

  localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(DEPTH);

  logic [CNT_W-1:0]           depth_q;
  logic [AW-1:0]              start_q;
  logic [DIMS-1:0][CNT_W-1:0] stride_q;
  logic [DIMS-1:0][CNT_W-1:0] range_q;
  logic                       err_q;
  logic                       load_ok;
  logic                       load_bad;

  wr_state_t                  w_state;
  wr_state_t                  w_next;
  rd_state_t                  r_state;
  rd_state_t                  r_next;
  logic [CNT_W-1:0]           wcnt_q;
  logic [CNT_W-1:0]           wcnt_d;
  logic                       bank_q;
  logic [CNT_W-1:0]           swap_cnt_q;
  logic                       swap;
  logic                       wr_fire;
  logic                       rd_fire;
  logic                       rd_last;
  logic [AW-1:0]              rd_addr;

  logic [DATA_W-1:0]          mem [2][DEPTH];

  assign load_ok  = cfg_load & ~cfg_busy;
  assign cfg_busy = (w_state != W_IDLE);
  assign cfg_err  = err_q;
  assign wr_ready = (w_state == W_FILL) & ~err_q;
  assign rd_valid = (r_state == R_DRAIN) & ~err_q;
  assign wr_bank  = bank_q;
  assign swap_cnt = swap_cnt_q;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;
  assign swap     = (w_state == W_DONE) & (r_state != R_DRAIN);

  // Validity of the config presented on the load port
  always_comb begin
    load_bad = (cfg_depth == '0) || ({1'b0, cfg_depth} > DEPTH_X);
    for (int d = 0; d < DIMS; d++) begin
      if (cfg_range[d] == '0) load_bad = 1'b1;
    end
  end

  // Config latch; loads are only taken while the writer is idle
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q  <= '0;
      start_q  <= '0;
      stride_q <= '0;
      for (int d = 0; d < DIMS; d++) range_q[d] <= CNT_W'(1);
      err_q    <= 1'b1;
    end else if (load_ok) begin
      depth_q  <= cfg_depth;
      start_q  <= cfg_start;
      stride_q <= cfg_stride;
      range_q  <= cfg_range;
      err_q    <= load_bad;
    end
  end

  // Writer and reader next-state logic; both restart together on a swap
  always_comb begin
    w_next = w_state;
    r_next = r_state;
    wcnt_d = wcnt_q;
    case (w_state)
      W_IDLE: begin
        if (load_ok ? ~load_bad : ~err_q) begin
          w_next = W_FILL;
          wcnt_d = '0;
        end
      end
      W_FILL: begin
        if (wr_fire) begin
          wcnt_d = wcnt_q + CNT_W'(1);
          if (wcnt_q == depth_q - CNT_W'(1)) w_next = W_DONE;
        end
      end
      W_DONE: begin
        if (swap) begin
          w_next = W_FILL;
          wcnt_d = '0;
        end
      end
      default: w_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (swap) r_next = R_DRAIN;
      R_DRAIN: if (rd_fire && rd_last) r_next = R_DONE;
      R_DONE:  if (swap) r_next = R_DRAIN;
      default: r_next = R_IDLE;
    endcase
  end

  // State, fill counter, bank select and swap counter
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      wcnt_q     <= '0;
      bank_q     <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      wcnt_q  <= wcnt_d;
      if (swap) begin
        bank_q     <= ~bank_q;
        swap_cnt_q <= swap_cnt_q + CNT_W'(1);
      end
    end
  end

  // Bank storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_fire) mem[bank_q][wcnt_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = rd_valid ? mem[~bank_q][rd_addr] : '0;

  db_agen #(
    .DIMS  (DIMS),
    .CNT_W (CNT_W),
    .AW    (AW)
  ) u_agen (
    .clk    (clk),
    .reset  (reset),
    .start  (swap),
    .step   (rd_fire),
    .base   (start_q),
    .stride (stride_q),
    .range  (range_q),
    .addr   (rd_addr),
    .last   (rd_last)
  );

endmodule

// File: tb/tb_db_agen_buffer.sv
// Directed bench for db_agen_buffer: fill/drain ordering, stride patterns, wrap, errors, reset.
`timescale 1ns/1ps
module tb_db_agen_buffer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned DIMS   = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned AW     = 6;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       cfg_load;
  logic [CNT_W-1:0]           cfg_depth;
  logic [AW-1:0]              cfg_start;
  logic [DIMS-1:0][CNT_W-1:0] cfg_stride;
  logic [DIMS-1:0][CNT_W-1:0] cfg_range;
  logic                       cfg_busy;
  logic                       cfg_err;
  logic                       wr_valid;
  logic                       wr_ready;
  logic [DATA_W-1:0]          wr_data;
  logic                       rd_valid;
  logic                       rd_ready;
  logic [DATA_W-1:0]          rd_data;
  logic                       wr_bank;
  logic [CNT_W-1:0]           swap_cnt;

  int n_chk;
  int n_bad;
  int step_n;
  int rd_mode;
  int words_wr;
  int first_depth;
  int t_last;
  bit saw_stall;
  bit mbank;

  logic [DATA_W-1:0] wq[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] rd_log[$];
  logic [CNT_W-1:0]  sc_hist[$];
  bit                rv_hist[$];
  logic [DATA_W-1:0] mmem [2][DEPTH];

  db_agen_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DIMS   (DIMS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_depth  (cfg_depth),
    .cfg_start  (cfg_start),
    .cfg_stride (cfg_stride),
    .cfg_range  (cfg_range),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .wr_bank    (wr_bank),
    .swap_cnt   (swap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, then account for the handshakes the next posedge takes
  task automatic tick();
    @(negedge clk);
    cfg_load = 1'b0;
    wr_valid = (wq.size() > 0);
    wr_data  = (wq.size() > 0) ? wq[0] : '0;
    case (rd_mode)
      0:       rd_ready = 1'b0;
      1:       rd_ready = 1'b1;
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
    sc_hist.push_back(swap_cnt);
    rv_hist.push_back(rd_valid);
    if (wr_valid && !wr_ready && rd_valid) saw_stall = 1'b1;
    if (wr_valid && wr_ready) begin
      void'(wq.pop_front());
      words_wr++;
      if (words_wr == first_depth) t_last = step_n;
    end
    if (rd_valid && rd_ready) rd_log.push_back(rd_data);
    step_n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    cfg_load = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    exp_q.delete();
    rd_log.delete();
    mbank = 1'b0;
  endtask

  task automatic load_cfg(input int depth, input int start, input int s0, input int s1,
                          input int s2, input int r0, input int r1, input int r2);
    @(negedge clk);
    cfg_depth  = CNT_W'(depth);
    cfg_start  = AW'(start);
    cfg_stride = {CNT_W'(s2), CNT_W'(s1), CNT_W'(s0)};
    cfg_range  = {CNT_W'(r2), CNT_W'(r1), CNT_W'(r0)};
    cfg_load   = 1'b1;
    wr_valid   = 1'b0;
    rd_ready   = 1'b0;
  endtask

  // Load config, stream nfill fills, collect reads and compare against the bank model
  task automatic run(input string tag, input int nfill, input int depth, input int start,
                     input int s0, input int s1, input int s2,
                     input int r0, input int r1, input int r2,
                     input int vbase, input int mode, input int stop, input int budget,
                     input bit lat);
    int n;
    int cyc;
    int a;
    int v;
    wq.delete();
    exp_q.delete();
    rd_log.delete();
    words_wr    = 0;
    first_depth = depth;
    t_last      = -1;
    saw_stall   = 1'b0;
    rd_mode     = mode;
    for (int f = 0; f < nfill; f++) begin
      for (int i = 0; i < depth; i++) begin
        v = vbase + f * depth + i;
        wq.push_back(DATA_W'(v));
        mmem[mbank][i] = DATA_W'(v);
      end
      for (int i2 = 0; i2 < r2; i2++)
        for (int i1 = 0; i1 < r1; i1++)
          for (int i0 = 0; i0 < r0; i0++) begin
            a = (start + i0 * s0 + i1 * s1 + i2 * s2) % DEPTH;
            exp_q.push_back(mmem[mbank][a]);
          end
      mbank = ~mbank;
    end
    load_cfg(depth, start, s0, s1, s2, r0, r1, r2);
    n   = (stop > 0) ? stop : exp_q.size();
    cyc = 0;
    while (rd_log.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    chk($sformatf("%s_nreads", tag), 32'(rd_log.size()), 32'(n));
    for (int i = 0; i < rd_log.size() && i < n; i++)
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_log[i]), 32'(exp_q[i]));
    if (lat) begin
      chk($sformatf("%s_last_seen", tag), 32'(t_last >= 0), 32'd1);
      if (t_last >= 0 && t_last + 2 < sc_hist.size()) begin
        chk($sformatf("%s_rv_t1", tag), 32'(rv_hist[t_last+1]), 32'd0);
        chk($sformatf("%s_rv_t2", tag), 32'(rv_hist[t_last+2]), 32'd1);
        chk($sformatf("%s_sc_t2", tag), 32'(sc_hist[t_last+2]), 32'd1);
      end
    end
  endtask

  initial begin
    int rdy_cnt;
    n_chk      = 0;
    n_bad      = 0;
    step_n     = 0;
    rd_mode    = 1;
    mbank      = 1'b0;
    reset      = 1'b1;
    cfg_load   = 1'b0;
    cfg_depth  = '0;
    cfg_start  = '0;
    cfg_stride = '0;
    cfg_range  = '0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    rd_ready   = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    chk("rst_wr_bank",  32'(wr_bank),  32'd0);
    chk("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    chk("rst_busy",     32'(cfg_busy), 32'd0);
    chk("rst_err",      32'(cfg_err),  32'd1);

    // Sequential 3x3x3 readout, with write-to-read latency
    run("seq", 1, 27, 0, 1, 3, 9, 3, 3, 3, 0, 1, 0, 200, 1'b1);
    chk("seq_swap_cnt", 32'(swap_cnt), 32'd1);
    chk("seq_wr_bank",  32'(wr_bank),  32'd1);
    chk("seq_busy",     32'(cfg_busy), 32'd1);
    // Invalid load while busy must not reach the config
    load_cfg(27, 0, 1, 3, 9, 3, 0, 3);
    tick();
    chk("busy_load_err", 32'(cfg_err), 32'd0);

    // Transpose
    do_reset();
    run("tr", 1, 27, 0, 9, 3, 1, 3, 3, 3, 0, 1, 0, 200, 1'b0);
    chk("tr_hand1", 32'(rd_log[1]), 32'd9);
    chk("tr_hand3", 32'(rd_log[3]), 32'd3);
    chk("tr_hand9", 32'(rd_log[9]), 32'd1);

    // Four back-to-back fills with a randomly stalling reader
    do_reset();
    run("strm", 4, 27, 0, 1, 3, 9, 3, 3, 3, 1000, 2, 0, 2000, 1'b0);
    chk("strm_stall",    32'(saw_stall), 32'd1);
    chk("strm_swap_cnt", 32'(swap_cnt),  32'd4);

    // Address wrap past the top of the bank
    do_reset();
    run("wrap", 1, 64, 60, 1, 0, 0, 8, 1, 1, 500, 1, 0, 300, 1'b0);
    chk("wrap_hand0", 32'(rd_log[0]), 32'd560);
    chk("wrap_hand4", 32'(rd_log[4]), 32'd500);

    // Zero range is rejected and the writer never opens
    do_reset();
    load_cfg(27, 0, 1, 3, 9, 3, 0, 3);
    for (int i = 0; i < 4; i++) wq.push_back(DATA_W'(i));
    tick();
    chk("err_flag", 32'(cfg_err), 32'd1);
    rdy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_ready) rdy_cnt++;
    end
    chk("err_ready_cnt", 32'(rdy_cnt),  32'd0);
    chk("err_busy",      32'(cfg_busy), 32'd0);

    // Reset in the middle of a drain, then a clean fill
    do_reset();
    run("mid", 1, 27, 0, 1, 3, 9, 3, 3, 3, 64, 1, 5, 200, 1'b0);
    do_reset();
    chk("mid_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_wr_bank",  32'(wr_bank),  32'd0);
    chk("mid_swap_cnt", 32'(swap_cnt), 32'd0);
    chk("mid_err",      32'(cfg_err),  32'd1);
    run("post", 1, 27, 0, 1, 3, 9, 3, 3, 3, 128, 1, 0, 200, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
